// File: rtl/div_scheduler.sv
// Two-requester round-robin front end for a shared W-bit restoring divider.
// One operation in flight; the result is held until the consumer takes it.
module div_scheduler #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   input  logic         req1_valid,
   output logic         req0_ready,
   output logic         req1_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_q,
   output logic [W-1:0] rsp_r,
   output logic         rsp_dz,
   output logic         busy
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t          r_state;
   logic            r_ptr;
   logic            r_id;
   logic [2*W-1:0]  r_rq;
   logic [W-1:0]    r_b;
   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    r_rsp_q;
   logic [W-1:0]    r_rsp_r;
   logic            r_rsp_id;
   logic            r_rsp_dz;

   logic            w_grant1;
   logic            w_accept;
   logic [W-1:0]    w_a;
   logic [W-1:0]    w_b;
   logic [W:0]      w_rem_sh;
   logic [W:0]      w_diff;
   logic [2*W-1:0]  w_rq_next;

   // With both requests valid the pointer decides; a lone request always wins.
   assign w_grant1   = req1_valid & (~req0_valid | r_ptr);
   assign w_accept   = (r_state == S_IDLE) & (req0_valid | req1_valid);
   assign req0_ready = w_accept & ~w_grant1;
   assign req1_ready = w_accept &  w_grant1;
   assign w_a        = w_grant1 ? req1_a : req0_a;
   assign w_b        = w_grant1 ? req1_b : req0_b;

   // Shifted partial remainder keeps the bit pushed out of R, so the
   // compare/subtract is W+1 bits wide and cannot overflow. A zero divisor
   // always "fits", which yields q = all ones and r = a with no special case.
   assign w_rem_sh  = r_rq[2*W-1:W-1];
   assign w_diff    = w_rem_sh - {1'b0, r_b};
   assign w_rq_next = w_diff[W] ? {w_rem_sh[W-1:0], r_rq[W-2:0], 1'b0}
                                : {w_diff[W-1:0],   r_rq[W-2:0], 1'b1};

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_ptr    <= 1'b0;
         r_id     <= 1'b0;
         r_rq     <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_rsp_q  <= '0;
         r_rsp_r  <= '0;
         r_rsp_id <= 1'b0;
         r_rsp_dz <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_rq    <= {{W{1'b0}}, w_a};
                  r_b     <= w_b;
                  r_id    <= w_grant1;
                  r_ptr   <= ~w_grant1;
                  r_cnt   <= '0;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_rq  <= w_rq_next;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(W - 1)) begin
                  r_rsp_q  <= w_rq_next[W-1:0];
                  r_rsp_r  <= w_rq_next[2*W-1:W];
                  r_rsp_id <= r_id;
                  r_rsp_dz <= (r_b == '0);
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               if (rsp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign rsp_q     = r_rsp_q;
   assign rsp_r     = r_rsp_r;
   assign rsp_id    = r_rsp_id;
   assign rsp_dz    = r_rsp_dz;

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler (W=4): vector table, arbitration,
// back-pressure, mid-operation reset and an exhaustive divide sweep.
module tb_div_scheduler;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_dz, busy;
   logic [W-1:0] rsp_q, rsp_r;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic         id;
      logic [W-1:0] a, b, q, r;
      logic         dz;
   } vec_t;

   vec_t vecs [7];

   always #5 clk = ~clk;

   div_scheduler #(.W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_q      (rsp_q),
      .rsp_r      (rsp_r),
      .rsp_dz     (rsp_dz),
      .busy       (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called just after the accept edge; returns at the first negedge with rsp_valid.
   task automatic wait_resp(input logic id, input logic [W-1:0] q, input logic [W-1:0] r,
                            input logic dz, input bit drop);
      int lat;
      int k;
      lat = 0;
      k   = 0;
      #1;
      if (drop) begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         req0_a = ~req0_a;
         req0_b = ~req0_b;
         req1_a = ~req1_a;
         req1_b = ~req1_b;
      end
      while (lat == 0 && k < 20) begin
         @(negedge clk);
         k++;
         if (k == 1 && !drop)
            check("ready_low_in_calc", 32'({req1_ready, req0_ready}), 32'(0));
         if (rsp_valid) lat = k;
      end
      check("latency", 32'(lat), 32'(W + 1));
      check("rsp_id", 32'(rsp_id), 32'(id));
      check("rsp_q", 32'(rsp_q), 32'(q));
      check("rsp_r", 32'(rsp_r), 32'(r));
      check("rsp_dz", 32'(rsp_dz), 32'(dz));
   endtask

   task automatic finish_hs();
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rsp_valid_drop", 32'(rsp_valid), 32'(0));
      check("busy_idle", 32'(busy), 32'(0));
   endtask

   // Entered and left on a negedge.
   task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b;
      end
      rsp_ready = 1'b1;
      #1 check("grant", 32'({req1_ready, req0_ready}), 32'({id, ~id}));
      @(posedge clk);
      wait_resp(id, q, r, dz, 1'b1);
      finish_hs();
   endtask

   initial begin
      int quiet_bad;
      logic [W-1:0] mq, mr;

      vecs[0] = '{id: 1'b0, a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, dz: 1'b0};
      vecs[1] = '{id: 1'b1, a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, dz: 1'b1};
      vecs[2] = '{id: 1'b0, a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0};
      vecs[3] = '{id: 1'b1, a: 4'd7,  b: 4'd8,  q: 4'd0,  r: 4'd7, dz: 1'b0};
      vecs[4] = '{id: 1'b0, a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0};
      vecs[5] = '{id: 1'b1, a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0};
      vecs[6] = '{id: 1'b0, a: 4'd14, b: 4'd4,  q: 4'd3,  r: 4'd2, dz: 1'b0};

      rst_n = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      rsp_ready = 1'b0;
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs",
            32'({rsp_valid, busy, rsp_q, rsp_r, rsp_id, rsp_dz, req0_ready, req1_ready}), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i])
         run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

      // Both requesters valid every cycle straight after reset: grants alternate from 0.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 4'd11; req0_b = 4'd2;
      req1_valid = 1'b1; req1_a = 4'd6;  req1_b = 4'd4;
      rsp_ready  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 check("alt_grant", 32'({req1_ready, req0_ready}), (i % 2 == 1) ? 32'd2 : 32'd1);
         @(posedge clk);
         if (i % 2 == 1) wait_resp(1'b1, 4'd1, 4'd2, 1'b0, 1'b0);
         else            wait_resp(1'b0, 4'd5, 4'd1, 1'b0, 1'b0);
         finish_hs();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Back-pressure: response held ten cycles while both requesters wait.
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 4'd10; req0_b = 4'd3;
      rsp_ready  = 1'b0;
      #1 check("stall_grant", 32'({req1_ready, req0_ready}), 32'd1);
      @(posedge clk);
      wait_resp(1'b0, 4'd3, 4'd1, 1'b0, 1'b1);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_hold",
               32'({rsp_valid, rsp_q, rsp_r, rsp_id, rsp_dz, req0_ready, req1_ready}),
               32'({1'b1, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0}));
      end
      finish_hs();
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Mid-calculation reset: pointer left at 1 beforehand, must return to 0.
      @(negedge clk);
      run_op(1'b0, 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
      req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd2;
      #1 check("rst_test_grant", 32'({req1_ready, req0_ready}), 32'd1);
      @(posedge clk);
      #1 req0_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1 check("async_reset_outputs",
               32'({rsp_valid, busy, rsp_q, rsp_r, rsp_id, rsp_dz, req0_ready, req1_ready}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      quiet_bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet_bad++;
      end
      check("no_rsp_after_reset", 32'(quiet_bad), 32'(0));
      req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5;
      req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd2;
      rsp_ready  = 1'b1;
      #1 check("post_reset_grant", 32'({req1_ready, req0_ready}), 32'd1);
      @(posedge clk);
      wait_resp(1'b0, 4'd4, 4'd1, 1'b0, 1'b1);
      finish_hs();

      // Exhaustive sweep through requester 0 against a behavioural model.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0) begin
               mq = 4'hF;
               mr = W'(a);
            end else begin
               mq = W'(a / b);
               mr = W'(a % b);
            end
            run_op(1'b0, W'(a), W'(b), mq, mr, (b == 0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div_scheduler.md
DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 Parameter: W, default 4, operand/result width in bits (legal range 2..16).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester 0/1 has an operation pending.
REQ-005 req0_ready, req1_ready  output  1 each  operation accepted this cycle.
REQ-006 req0_a, req1_a  input  W each  dividend.
REQ-007 req0_b, req1_b  input  W each  divisor.
REQ-008 rsp_valid  output  1  result held on rsp_* bus.
REQ-009 rsp_ready  input  1  consumer takes the result.
REQ-010 rsp_id  output  1  requester that owns the result.
REQ-011 rsp_q, rsp_r  output  W each  quotient and remainder.
REQ-012 rsp_dz  output  1  divisor was zero.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, CALC and DONE.
REQ-015 In IDLE with at least one reqN_valid, the block SHALL assert exactly one reqN_ready, combinationally, for the granted requester.
REQ-016 When both requests are valid, the grant SHALL go to the requester named by the 1-bit priority pointer.
REQ-017 After each grant, the pointer SHALL point to the non-granted requester (round-robin).
REQ-018 When only one request is valid, it SHALL be granted regardless of the pointer, and the pointer SHALL still be updated per REQ-017.
REQ-019 On grant, the block SHALL capture a, b and id into internal registers and move IDLE->CALC.
REQ-020 The operands SHALL be sampled only on the accept edge; later input changes SHALL have no effect.
REQ-021 The reqN_ready outputs SHALL be 0 in CALC and DONE.
REQ-022 CALC SHALL run exactly W restoring-division iterations, one per cycle, on a 2W-bit {R,Q} register initialised to {0,a}.
REQ-023 Each iteration SHALL shift {R,Q} left by 1.
REQ-024 After the shift, if R>=b the block SHALL set R=R-b and Q[0]=1; otherwise it SHALL set Q[0]=0.
REQ-025 The compare and subtract SHALL use W+1 bits so that no overflow occurs.
REQ-026 After the W-th iteration the FSM SHALL move CALC->DONE.
REQ-027 In DONE, rsp_valid SHALL be 1 and rsp_q, rsp_r, rsp_id and rsp_dz SHALL be stable until the handshake.
REQ-028 rsp_valid SHALL first be 1 in cycle N+W+1 for an accept edge at cycle N (N+5 when W=4).
REQ-029 When rsp_valid and rsp_ready are both 1, the FSM SHALL move DONE->IDLE and rsp_valid SHALL fall in the next cycle.
REQ-030 A new grant SHALL be possible no earlier than the first IDLE cycle after the handshake; back-to-back throughput is one operation per W+2 cycles.
REQ-031 When rsp_ready is held low, the block SHALL stay in DONE indefinitely and accept no requests.
REQ-032 When b==0, rsp_dz SHALL be 1, rsp_q SHALL be all ones and rsp_r SHALL equal a, with timing identical to REQ-028.
REQ-033 rsp_q, rsp_r, rsp_id and rsp_dz SHALL hold their last values outside DONE; their values are only meaningful while rsp_valid=1.

Reset
REQ-034 While rst_n=0, the block SHALL force the state to IDLE, the pointer to requester 0, and rsp_valid, rsp_q, rsp_r, rsp_id, rsp_dz and busy all to 0, asynchronously.
REQ-035 Reset asserted in CALC or DONE SHALL abandon the operation with no response issued; the dropped requester must re-request.
REQ-036 On the first clk edge after rst_n rises, the block SHALL behave as IDLE with the pointer at requester 0.

Verification
REQ-037 The bench SHALL cover: W=4, req0 a=13 b=3, rsp_ready=1 -> rsp_q=4, rsp_r=1, rsp_id=0, rsp_dz=0, rsp_valid first high 5 cycles after accept.
REQ-038 The bench SHALL cover: both valid every cycle after reset, rsp_ready=1 -> grants alternate 0,1,0,1, each response carrying its own operands' result.
REQ-039 The bench SHALL cover: req1 a=9 b=0 -> rsp_dz=1, rsp_q=15, rsp_r=9, rsp_id=1.
REQ-040 The bench SHALL cover: rsp_ready held 0 for 10 cycles in DONE -> rsp_* stable, req0_ready=req1_ready=0 throughout; handshake then IDLE next cycle.
REQ-041 The bench SHALL cover: rst_n pulsed low on the 2nd CALC cycle -> all outputs 0 immediately, no rsp_valid afterwards, next grant goes to requester 0.
REQ-042 The bench SHALL cover: exhaustive a,b in 0..15 via req0 against a reference model -> q=a/b and r=a%b for b!=0, and REQ-032 values for b=0.
